mc_muldiv: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit with HI/LO result registers.

---
 rtl/mc_muldiv.sv | 171 +++++++++++++++++
 tb/tb_mc_muldiv.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mc_muldiv.sv
// rtl/mc_muldiv.sv - multi-cycle multiply/divide unit with HI/LO result registers
// One result bit per cycle: shift-add multiply (LSB first), restoring divide (MSB first).

module mc_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     dvsr_q, dvsr_d;
  logic                 is_div_q, is_div_d;
  logic                 sa_q, sa_d;
  logic                 sb_q, sb_d;
  logic                 dz_q, dz_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 dzo_q, dzo_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       rem_sh, rem_sub;
  logic                 rem_ge;
  logic [WIDTH-1:0]     rem_new;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_neg;
  logic                 b_zero;

  assign a_abs  = (op[0] && a[WIDTH-1]) ? -a : a;
  assign b_abs  = (op[0] && b[WIDTH-1]) ? -b : b;
  assign b_zero = (b == '0);

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvsr_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}. Remainder stays below the divisor, so the
  // borrow out of the WIDTH+1 bit subtract is exactly the unsigned compare result.
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_sub  = rem_sh - {1'b0, dvsr_q};
  assign rem_ge   = ~rem_sub[WIDTH];
  assign rem_new  = rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign div_next = {rem_new, acc_q[WIDTH-2:0], rem_ge};

  assign prod_neg = -acc_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    dvsr_d   = dvsr_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    dz_d     = dz_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dzo_d    = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (hi_wr) hi_d = wdata;
        if (lo_wr) lo_d = wdata;
        if (start) begin
          is_div_d = op[1];
          sa_d     = op[0] & a[WIDTH-1];
          sb_d     = op[0] & b[WIDTH-1];
          busy_d   = 1'b1;
          cnt_d    = CNT_MAX;
          dz_d     = op[1] & b_zero;
          if (op[1]) begin
            acc_d  = {{WIDTH{1'b0}}, a_abs};
            dvsr_d = b_abs;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, b_abs};
            dvsr_d = a_abs;
          end
          state_d = (op[1] && b_zero) ? FIX : RUN;
        end
      end
      RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dzo_d   = dz_q;
        dz_d    = 1'b0;
        if (!dz_q) begin
          if (is_div_q) begin
            lo_d = (sa_q ^ sb_q) ? prod_neg[WIDTH-1:0] : acc_q[WIDTH-1:0];
            hi_d = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          end else begin
            hi_d = (sa_q ^ sb_q) ? prod_neg[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            lo_d = (sa_q ^ sb_q) ? prod_neg[WIDTH-1:0] : acc_q[WIDTH-1:0];
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      dvsr_q   <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dzo_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      dvsr_q   <= dvsr_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dzo_q    <= dzo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dzo_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mc_muldiv.sv
// tb/tb_mc_muldiv.sv - directed self-checking bench for mc_muldiv
// Hand-computed vectors for multiply, divide, zero divisor, overflow, busy and reset behaviour.

module tb_mc_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         hi_wr = 1'b0;
  logic         lo_wr = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int total = 0;
  int passed = 0;
  int lat;
  logic dz;
  int seen_done;

  mc_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one op and wait for done; lat = edges from the start edge to done (0 = timeout).
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int l, output logic z);
    @(posedge clk); #1;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    l = 0;
    z = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        l = i;
        z = div_zero;
        break;
      end
    end
  endtask

  task automatic write_hilo(input logic wh, input logic wl, input logic [W-1:0] d);
    @(posedge clk); #1;
    hi_wr = wh; lo_wr = wl; wdata = d;
    @(posedge clk); #1;
    hi_wr = 1'b0; lo_wr = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_dz", div_zero, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    rst = 1'b1;

    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, dz);
    check("multu_lat", lat, 33);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);
    check("multu_busy_at_done", busy, 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);

    run_op(2'b01, 32'hFFFFFFFD, 32'h00000007, lat, dz);
    check("mult_neg_lat", lat, 33);
    check("mult_neg_hi", hi, 32'hFFFFFFFF);
    check("mult_neg_lo", lo, 32'hFFFFFFEB);

    run_op(2'b01, 32'h00000000, 32'h80000000, lat, dz);
    check("mult_zero_hi", hi, 0);
    check("mult_zero_lo", lo, 0);

    run_op(2'b11, 32'hFFFFFFF9, 32'h00000002, lat, dz);
    check("div_neg_lat", lat, 33);
    check("div_neg_lo", lo, 32'hFFFFFFFD);
    check("div_neg_hi", hi, 32'hFFFFFFFF);

    run_op(2'b10, 32'd100, 32'd7, lat, dz);
    check("divu_lo", lo, 32'h0000000E);
    check("divu_hi", hi, 32'h00000002);
    check("divu_dz", dz, 0);

    write_hilo(1'b1, 1'b0, 32'h12345678);
    write_hilo(1'b0, 1'b1, 32'h9ABCDEF0);
    check("mthi", hi, 32'h12345678);
    check("mtlo", lo, 32'h9ABCDEF0);
    run_op(2'b11, 32'h00000055, 32'h00000000, lat, dz);
    check("dz_lat", lat, 1);
    check("dz_flag", dz, 1);
    check("dz_busy", busy, 0);
    check("dz_hi", hi, 32'h12345678);
    check("dz_lo", lo, 32'h9ABCDEF0);
    @(posedge clk); #1;
    check("dz_pulse_end", div_zero, 0);

    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, lat, dz);
    check("ovf_lo", lo, 32'h80000000);
    check("ovf_hi", hi, 32'h00000000);
    check("ovf_dz", dz, 0);

    write_hilo(1'b1, 1'b1, 32'hA5A5A5A5);
    check("mthilo_hi", hi, 32'hA5A5A5A5);
    check("mthilo_lo", lo, 32'hA5A5A5A5);

    // MULTU 3x5 with a second start and an MTHI pulsed mid-run; both must be dropped.
    @(posedge clk); #1;
    op = 2'b00; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    repeat (10) @(posedge clk);
    #1;
    op = 2'b10; a = 32'd1000; b = 32'd3; start = 1'b1; hi_wr = 1'b1; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    start = 1'b0; hi_wr = 1'b0;
    check("busy_mtHI_dropped", hi, 32'hA5A5A5A5);
    lat = 0;
    for (int i = 12; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    check("ignored_start_lat", lat, 33);
    check("ignored_start_hi", hi, 0);
    check("ignored_start_lo", lo, 32'h0000000F);
    @(posedge clk); #1;
    check("no_second_op", busy, 0);

    // Same op, reset dropped mid-run.
    write_hilo(1'b1, 1'b1, 32'hA5A5A5A5);
    @(posedge clk); #1;
    op = 2'b00; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_hi", hi, 0);
    check("rst_mid_lo", lo, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    seen_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    check("rst_mid_no_done", seen_done, 0);

    run_op(2'b10, 32'd100, 32'd7, lat, dz);
    check("post_rst_lat", lat, 33);
    check("post_rst_lo", lo, 32'h0000000E);
    check("post_rst_hi", hi, 32'h00000002);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
